// File: rtl/bandit_pkg.sv
// Shared definitions for the epsilon-greedy bandit agent.
//   state_t      : trial sequencer states (SCAN, ACTION, REWARD, UPDATE)
//   LFSR_POLY    : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   DEFAULT_SEED : nonzero LFSR reset value used when none is supplied
package bandit_pkg;

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        ACTION = 2'd1,
        REWARD = 2'd2,
        UPDATE = 2'd3
    } state_t;

    // Right-shifting Galois form: taps 16,14,13,11 map onto bits 15,13,12,10.
    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/bandit_lfsr.sv
// 16-bit Galois LFSR used as the exploration random source.
// Ports:
//   clock   : system clock, posedge
//   reset   : synchronous active-high, loads SEED
//   advance : step the register by one shift when high
//   state   : current LFSR contents
module bandit_lfsr
    import bandit_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] state
);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SEED;
        end else if (advance) begin
            // Bit shifted out of position 0 is folded back into the tap positions.
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/epsilon_bandit.sv
// Epsilon-greedy multi-armed bandit agent.
// Each trial: scan the action-value table for the argmax (one entry per
// cycle), optionally replace it with a random exploratory action, offer the
// action, wait for the reward, then move the chosen entry toward the reward
// by 2^-ALPHA_SHIFT of the error.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. action_valid is only raised in ACTION and holds
// action_data/action_explore stable until the transfer; reward_ready is only
// raised in REWARD. Inputs outside those states are ignored.
//
// Ports:
//   clock, reset   : system clock and synchronous active-high reset
//   action_valid   : an action is offered
//   action_data    : chosen action index
//   action_explore : offered action is exploratory (qualified by action_valid)
//   action_ready   : consumer accepts the action
//   reward_valid   : reward is offered
//   reward_data    : signed reward for the last accepted action
//   reward_ready   : agent accepts the reward
module epsilon_bandit
    import bandit_pkg::*;
#(
    parameter int          NUM_ACTIONS  = 256,
    parameter int          ACTION_WIDTH = $clog2(NUM_ACTIONS),
    parameter int          VALUE_WIDTH  = 8,
    parameter int          REWARD_WIDTH = 8,
    parameter int          ALPHA_SHIFT  = 1,
    parameter int          INIT_VALUE   = 5,
    parameter int          EPSILON      = 0,
    parameter logic [15:0] SEED         = DEFAULT_SEED
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    action_valid,
    output logic [ACTION_WIDTH-1:0] action_data,
    output logic                    action_explore,
    input  logic                    action_ready,
    input  logic                    reward_valid,
    input  logic [REWARD_WIDTH-1:0] reward_data,
    output logic                    reward_ready
);

    localparam logic signed [VALUE_WIDTH-1:0] INIT_Q    = VALUE_WIDTH'(INIT_VALUE);
    localparam logic [ACTION_WIDTH-1:0]       SCAN_LAST = ACTION_WIDTH'(NUM_ACTIONS - 1);
    localparam logic [9:0]                    EPS_EXT   = 10'(EPSILON);

    state_t state;
    state_t state_next;

    logic signed [VALUE_WIDTH-1:0] q_table [NUM_ACTIONS];

    logic [ACTION_WIDTH-1:0]       scan_idx;
    logic signed [VALUE_WIDTH-1:0] best_val;
    logic [ACTION_WIDTH-1:0]       best_idx;
    logic [ACTION_WIDTH-1:0]       act_reg;
    logic                          explore_reg;
    logic [REWARD_WIDTH-1:0]       reward_reg;

    logic [15:0] lfsr_state;

    // ---------------- random source ----------------
    bandit_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .advance(state == UPDATE),
        .state  (lfsr_state)
    );

    // ---------------- sequencer ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    logic scan_last;
    assign scan_last = (scan_idx == SCAN_LAST);

    always_comb begin
        state_next   = state;
        action_valid = 1'b0;
        reward_ready = 1'b0;
        case (state)
            SCAN: begin
                if (scan_last) state_next = ACTION;
            end
            ACTION: begin
                action_valid = 1'b1;
                if (action_ready) state_next = REWARD;
            end
            REWARD: begin
                reward_ready = 1'b1;
                if (reward_valid) state_next = UPDATE;
            end
            UPDATE: begin
                state_next = SCAN;
            end
            default: begin
                state_next = SCAN;
            end
        endcase
    end

    assign action_data    = act_reg;
    assign action_explore = explore_reg;

    // ---------------- argmax scan ----------------
    logic signed [VALUE_WIDTH-1:0] cur_val;
    logic signed [VALUE_WIDTH-1:0] cand_val;
    logic [ACTION_WIDTH-1:0]       cand_idx;
    logic [9:0]                    eps_diff;
    logic                          explore_now;

    always_comb begin
        cur_val = q_table[scan_idx];
        // Index 0 seeds the running max; afterwards only a strictly larger
        // value replaces it, so ties keep the lowest index.
        if (scan_idx == '0 || cur_val > best_val) begin
            cand_val = cur_val;
            cand_idx = scan_idx;
        end else begin
            cand_val = best_val;
            cand_idx = best_idx;
        end
    end

    // lfsr[15:8] < EPSILON, evaluated as the borrow of a 10-bit subtraction.
    assign eps_diff    = {2'b00, lfsr_state[15:8]} - EPS_EXT;
    assign explore_now = eps_diff[9];

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_idx    <= '0;
            best_val    <= '0;
            best_idx    <= '0;
            act_reg     <= '0;
            explore_reg <= 1'b0;
            reward_reg  <= '0;
        end else begin
            case (state)
                SCAN: begin
                    // Power-of-two table: the index wraps back to 0 after the last entry.
                    scan_idx <= scan_idx + 1'b1;
                    best_val <= cand_val;
                    best_idx <= cand_idx;
                    if (scan_last) begin
                        if (explore_now) begin
                            act_reg     <= lfsr_state[ACTION_WIDTH-1:0];
                            explore_reg <= 1'b1;
                        end else begin
                            act_reg     <= cand_idx;
                            explore_reg <= 1'b0;
                        end
                    end
                end
                REWARD: begin
                    if (reward_valid) reward_reg <= reward_data;
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- value update ----------------
    // One extra bit holds reward - Q without overflow; the result always lies
    // between Q and the reward, so truncating back to VALUE_WIDTH is exact.
    logic signed [VALUE_WIDTH-1:0] q_old;
    logic signed [VALUE_WIDTH:0]   reward_ext;
    logic signed [VALUE_WIDTH:0]   q_ext;
    logic signed [VALUE_WIDTH:0]   diff;
    logic signed [VALUE_WIDTH:0]   delta;
    logic signed [VALUE_WIDTH-1:0] q_new;

    always_comb begin
        q_old      = q_table[act_reg];
        reward_ext = {{(VALUE_WIDTH + 1 - REWARD_WIDTH){reward_reg[REWARD_WIDTH-1]}}, reward_reg};
        q_ext      = {q_old[VALUE_WIDTH-1], q_old};
        diff       = reward_ext - q_ext;
        delta      = diff >>> ALPHA_SHIFT;
        q_new      = VALUE_WIDTH'(q_ext + delta);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACTIONS; i++) begin
                q_table[i] <= INIT_Q;
            end
        end else if (state == UPDATE) begin
            q_table[act_reg] <= q_new;
        end
    end

endmodule
